split_merge: RTL
================

Name: split_merge

Overview:
- Reassembly counterpart of the split datapath: accepts narrow fragments one per handshake and packs them into a wide word.
- Presents the packed word on a valid/ready output.
- Sits on the receive side of any path that was split into FRAG_W-bit slices; restores the original word width for downstream logic.
- Single-entry output buffer with a two-state controller and a fragment counter.

Parameters:
- FRAG_W, 6: width of one fragment in bits.
- NUM_FRAGS, 2: fragments per full word; legal range 2..16.
- CNT_W, $clog2(NUM_FRAGS+1): width of the fragment counter and of out_count.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  fragment present on in_data.
- in_ready  output  1  block can accept a fragment.
- in_data  input  FRAG_W  fragment payload.
- in_last  input  1  fragment ends the word early; sampled only on handshake.
- out_valid  output  1  packed word available.
- out_ready  input  1  consumer accepts the word.
- out_data  output  FRAG_W*NUM_FRAGS  packed word; fragment k at bits [k*FRAG_W +: FRAG_W].
- out_count  output  CNT_W  number of fragments in out_data, 1..NUM_FRAGS.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (async assert, sync deassert at integration):
  - state=FILL, frag counter=0.
  - out_valid=0, out_data=0, out_count=0.
  - in_ready=1, since it is decoded from state FILL.
- States:
  - FILL: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Input handshake: in_valid && in_ready at a rising edge.
- Ordering: first fragment of a word goes to slot 0 (LSBs); each later fragment goes to the next higher slot.
- FILL, handshake, not last:
  - Not last means counter < NUM_FRAGS-1 and in_last=0.
  - Write slot[counter] and increment counter.
  - Stay in FILL.
- FILL, handshake, last:
  - Last means counter == NUM_FRAGS-1, or in_last=1.
  - Write slot[counter]; out_count <= counter+1; counter <= 0; go to HOLD.
  - out_valid rises the cycle after the final fragment handshake (latency 1).
- Zero padding: when a word ends early, slots above the last written slot read 0. Clear the buffer on entry to FILL, or mask on output.
- in_last on the final slot has the same effect as a normal last fragment; no extra word is produced.
- HOLD:
  - out_data and out_count are stable while out_valid=1 && out_ready=0.
  - On out_valid && out_ready, go to FILL next cycle; out_valid falls the same edge.
- No input/output overlap in the same cycle. Throughput is one full word per NUM_FRAGS+1 cycles under no backpressure.
- Backpressure of any length is held in HOLD with no data loss.
- Reset mid-word: all partially received fragments are discarded. The first fragment after reset lands in slot 0.
- in_data and in_last are don't-care when in_valid=0.

Optional Feature:
- Macro: SPLIT_MERGE_PARITY_EN.
- When defined:
  - Adds output port out_par (1 bit) = XOR reduction of out_data.
  - Registered alongside out_data; valid whenever out_valid=1.
  - Reset value 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Full word: reset, then send fragments 3 then 1 (in_last=0) -> next cycle out_valid=1, out_data=12'h043, out_count=2; with out_ready=1, in_ready=1 the following cycle.
- Early end: send 2 with in_last=1 -> out_data=12'h002, out_count=1; upper slot reads 0.
- Backpressure: complete word (4,1) with out_ready=0 for 3 cycles -> out_valid stays 1, out_data=12'h044 stable, in_ready=0; with out_ready=1 -> out_valid=0 next cycle.
- Reset mid-word: send 3, pull rst_n low for 1 cycle, then send 2, 3 -> out_data=12'h0C2, out_count=2; the 3 sent before reset is not present.
- Back-to-back: words (0,0), (2,0), (3,1) with out_ready tied 1 -> out_data 12'h000, 12'h002, 12'h043 in order, each out_valid pulse 1 cycle, 3 cycles per word.
- Parity (SPLIT_MERGE_PARITY_EN defined): word (3,1) -> out_par=1; word (3,0) -> out_par=0; out_par=0 after reset.

Source files
------------

// File: rtl/split_merge_if.sv
// Handshake bundle for split_merge: fragment input channel plus packed-word output channel.
// SPLIT_MERGE_PARITY_EN adds the out_par signal to the bundle.
interface split_merge_if #(
    parameter int FRAG_W    = 6,
    parameter int NUM_FRAGS = 2,
    parameter int CNT_W     = $clog2(NUM_FRAGS + 1)
) ();
    // Both channels: a transfer happens on a rising edge where valid && ready;
    // a sender holds valid and payload until accepted, ready never waits on valid.
    logic                        in_valid;
    logic                        in_ready;
    logic [FRAG_W-1:0]           in_data;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic [FRAG_W*NUM_FRAGS-1:0] out_data;
    logic [CNT_W-1:0]            out_count;
`ifdef SPLIT_MERGE_PARITY_EN
    logic                        out_par;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_par
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_par
    );
`else
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
`endif
endinterface

// File: rtl/split_merge.sv
// Packs FRAG_W-bit fragments (slot 0 first) into one wide word held in a single-entry buffer.
// Optional SPLIT_MERGE_PARITY_EN registers an XOR-reduction of the packed word as out_par.
module split_merge #(
    parameter int FRAG_W    = 6,
    parameter int NUM_FRAGS = 2,
    parameter int CNT_W     = $clog2(NUM_FRAGS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    split_merge_if.slave  bus,
    output logic          dbg_state
);
    localparam int DW = FRAG_W * NUM_FRAGS;

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic [DW-1:0]    buf_q, buf_d;
    logic [DW-1:0]    buf_wr;
    logic             in_hs;
    logic             out_hs;
    logic             is_last;
`ifdef SPLIT_MERGE_PARITY_EN
    logic             par_q, par_d;
`endif

    assign bus.in_ready  = (state_q == S_FILL);
    assign bus.out_valid = (state_q == S_HOLD);
    assign bus.out_data  = buf_q;
    assign bus.out_count = out_count_q;
    assign dbg_state     = (state_q == S_HOLD);
`ifdef SPLIT_MERGE_PARITY_EN
    assign bus.out_par   = par_q;
`endif

    assign in_hs   = bus.in_valid && bus.in_ready;
    assign out_hs  = bus.out_valid && bus.out_ready;
    assign is_last = bus.in_last || (cnt_q == CNT_W'(NUM_FRAGS - 1));

    // Buffer image with the incoming fragment dropped into the slot the counter points at.
    always_comb begin
        buf_wr = buf_q;
        for (int k = 0; k < NUM_FRAGS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                buf_wr[k*FRAG_W +: FRAG_W] = bus.in_data;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_count_d = out_count_q;
        buf_d       = buf_q;
`ifdef SPLIT_MERGE_PARITY_EN
        par_d       = par_q;
`endif
        case (state_q)
            S_FILL: begin
                if (in_hs) begin
                    buf_d = buf_wr;
                    if (is_last) begin
                        cnt_d       = '0;
                        out_count_d = cnt_q + CNT_W'(1);
                        state_d     = S_HOLD;
`ifdef SPLIT_MERGE_PARITY_EN
                        par_d       = ^buf_wr;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_HOLD: begin
                // Clearing here gives zero padding for the next word that ends early.
                if (out_hs) begin
                    state_d     = S_FILL;
                    buf_d       = '0;
                    out_count_d = '0;
`ifdef SPLIT_MERGE_PARITY_EN
                    par_d       = 1'b0;
`endif
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FILL;
            cnt_q       <= '0;
            out_count_q <= '0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_count_q <= out_count_d;
            buf_q       <= buf_d;
        end
    end

`ifdef SPLIT_MERGE_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.in_ready && bus.out_valid));

    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q < CNT_W'(NUM_FRAGS));

    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        bus.out_valid |-> (out_count_q >= CNT_W'(1) && out_count_q <= CNT_W'(NUM_FRAGS)));

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready) |=>
            (bus.out_valid && $stable(buf_q) && $stable(out_count_q)));

endmodule
